// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder_pkg
//  Description : Shared types and helpers for the MEM-stage data-memory
//                responder. Holds the FSM state encoding, the wait-state
//                counter width and the access error check.
//  Revision    : 1.0  initial release
// ============================================================================
package data_mem_responder_pkg;

    // Wide enough for WAIT_CYCLES up to 15.
    localparam int c_CNT_W = 4;

    typedef enum logic [1:0] {
        MEM_ST_IDLE = 2'd0,
        MEM_ST_WAIT = 2'd1,
        MEM_ST_DONE = 2'd2
    } mem_state_t;

    // An access is rejected when it is not word aligned, or when it asks
    // for a read and a write at the same time.
    function automatic logic access_err(input logic [1:0] addr_lo,
                                        input logic       ren,
                                        input logic       wen);
        return (addr_lo != 2'b00) || (ren && wen);
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_data_ram.sv
`default_nettype none
// ============================================================================
//  Module      : data_ram
//  Description : 2^ADDR_WIDTH x 32 word memory, synchronous write,
//                asynchronous read through a single shared address port.
//                Contents are never cleared by reset.
//  Ports       : clk   - clock
//                we    - write enable, commits wdata at the rising edge
//                addr  - word index
//                wdata - write data
//                rdata - combinational read of mem[addr]
//  Revision    : 1.0  initial release
// ============================================================================
module data_ram
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Data-memory responder at the far end of the MEM-stage
//                request interface. Serves LW/SW with WAIT_CYCLES wait
//                states, raising mem_stall while an access is in flight and
//                pulsing ack (with rdata/err) when it completes.
//  Ports       : clk, rst (sync, active-low)
//                req_valid/req_ren/req_wen/req_addr/req_wdata - request
//                mem_stall - pipeline hold while access in progress
//                ack       - one-cycle completion pulse
//                rdata     - load data, zero unless ack on a good read
//                err       - unaligned or read+write request, valid with ack
//  Revision    : 1.0  initial release
// ============================================================================
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_ren,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_stall,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam bit               c_ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [c_CNT_W-1:0] c_LOAD    =
        (WAIT_CYCLES > 0) ? c_CNT_W'(WAIT_CYCLES - 1) : '0;

    mem_state_t            r_state;
    mem_state_t            w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;

    logic [ADDR_WIDTH+1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_ren;
    logic                  r_wen;

    logic                  w_req;
    logic                  w_latch;
    logic                  w_serve;
    logic                  w_err;
    logic                  w_we;
    logic                  w_ren_sel;
    logic                  w_wen_sel;
    logic [ADDR_WIDTH+1:0] w_addr_sel;
    logic [31:0]           w_wdata_sel;
    logic [31:0]           w_ram_rdata;
    logic                  w_unused_addr_hi;

    // Upper address bits are ignored: addresses wrap modulo memory size.
    assign w_unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

    assign w_req = req_valid && (req_ren || req_wen);

    // In IDLE the only access that can be served is the zero-wait one, which
    // uses the live request. Everywhere else the latched copy is used so that
    // requester activity during the access has no effect.
    always_comb begin
        w_addr_sel  = r_addr;
        w_wdata_sel = r_wdata;
        w_ren_sel   = r_ren;
        w_wen_sel   = r_wen;
        if (r_state == MEM_ST_IDLE) begin
            w_addr_sel  = req_addr[ADDR_WIDTH+1:0];
            w_wdata_sel = req_wdata;
            w_ren_sel   = req_ren;
            w_wen_sel   = req_wen;
        end
    end

    assign w_err = access_err(w_addr_sel[1:0], w_ren_sel, w_wen_sel);

    // ------------------------------------------------------------------
    // FSM next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_latch     = 1'b0;
        w_serve     = 1'b0;
        mem_stall   = 1'b0;
        case (r_state)
            MEM_ST_IDLE: begin
                if (w_req) begin
                    if (c_ZERO_WAIT) begin
                        w_serve = 1'b1;
                    end else begin
                        mem_stall   = 1'b1;
                        w_latch     = 1'b1;
                        w_cnt_nxt   = c_LOAD;
                        w_state_nxt = (c_LOAD != '0) ? MEM_ST_WAIT : MEM_ST_DONE;
                    end
                end
            end
            MEM_ST_WAIT: begin
                mem_stall = 1'b1;
                w_cnt_nxt = r_cnt - 1'b1;
                // Leave when the count reaches zero on this edge, so the
                // stall lasts exactly WAIT_CYCLES cycles including IDLE.
                if (r_cnt <= 1) begin
                    w_state_nxt = MEM_ST_DONE;
                end
            end
            MEM_ST_DONE: begin
                w_serve     = 1'b1;
                w_state_nxt = MEM_ST_IDLE;
            end
            default: begin
                w_state_nxt = MEM_ST_IDLE;
            end
        endcase
    end

    assign ack   = w_serve;
    assign err   = w_serve && w_err;
    assign rdata = (w_serve && w_ren_sel && !w_err) ? w_ram_rdata : 32'h0;
    // Reset on the completing edge drops the write.
    assign w_we  = w_serve && w_wen_sel && !w_err && rst;

    // ------------------------------------------------------------------
    // State register and request latches
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= MEM_ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) begin
                r_addr  <= req_addr[ADDR_WIDTH+1:0];
                r_wdata <= req_wdata;
                r_ren   <= req_ren;
                r_wen   <= req_wen;
            end
        end
    end

    data_ram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_data_ram (
        .clk   (clk),
        .we    (w_we),
        .addr  (w_addr_sel[ADDR_WIDTH+1:2]),
        .wdata (w_wdata_sel),
        .rdata (w_ram_rdata)
    );

endmodule
`default_nettype wire

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder for the 5-stage pipelined MIPS CPU. It sits at the far end of the MEM-stage memory request interface: it serves the `mem_ren` / `mem_wen` requests that the controller decodes for LW and SW. Each access has a configurable number of wait states. While an access is in flight, the block raises `mem_stall` back toward the pipeline control so that the stages hold.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: word-index width; the memory holds 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, 2: stall cycles per access, range 0..15.

Ports:
- `clk`  in  1  main clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-low (`rst == 0` resets on the clock edge).
- `req_valid`  in  1  MEM stage holds a valid instruction.
- `req_ren`  in  1  read request (LW).
- `req_wen`  in  1  write request (SW).
- `req_addr`  in  32  byte address from the ALU result.
- `req_wdata`  in  32  store data, already forwarded.
- `mem_stall`  out  1  access in progress; pipeline must hold.
- `ack`  out  1  single-cycle completion pulse.
- `rdata`  out  32  load data; valid only while `ack` = 1, otherwise 0.
- `err`  out  1  error flag: unaligned address, or both `req_ren` and `req_wen` set; valid with `ack`.

## Operation
- Request means `req_valid && (req_ren || req_wen)`. It is sampled only in IDLE.
- Index = `req_addr[ADDR_WIDTH+1:2]`. Upper address bits are ignored, so addresses wrap modulo memory size.
- FSM states: IDLE, WAIT, DONE.
  - IDLE, no request: `mem_stall` = 0, `ack` = 0.
  - IDLE, request, `WAIT_CYCLES` = 0: served combinationally in the same cycle. `ack` = 1, `mem_stall` = 0. A write commits at the clock edge. State stays IDLE.
  - IDLE, request, `WAIT_CYCLES` >= 1: latch addr, wdata, ren, wen. Load counter = `WAIT_CYCLES` - 1. Assert `mem_stall` = 1 combinationally. Next state is WAIT if the counter is nonzero, else DONE.
  - WAIT: `mem_stall` = 1. Counter decrements each cycle; at 0, go to DONE.
  - DONE: `mem_stall` = 0, `ack` = 1, `rdata` = mem[latched index] for a read. A write commits at the edge ending DONE. Next state is IDLE unconditionally.
- A request still present in IDLE right after DONE is treated as a new access (debug-freeze case). A repeated read or write is idempotent.
- Unaligned (`addr[1:0] != 0`): `ack` with `err` = 1, `rdata` = 0, no write. Latency is unchanged.
- `req_ren` and `req_wen` both set: `err` = 1 and no memory access.
- Memory array is never cleared by reset.

## Timing
- Reset (`rst` = 0): state IDLE, counter 0, `mem_stall` 0, `ack` 0, `rdata` 0, `err` 0. A pending write is dropped, even if reset falls in DONE.
- Latency: `ack` arrives exactly `WAIT_CYCLES` cycles after the request cycle. `mem_stall` is high for exactly `WAIT_CYCLES` cycles.
- Requester inputs must be held stable while `mem_stall` = 1. Changes during WAIT are ignored because the latched copy is used.
- `req_valid` dropping mid-access does not abort the access; the pipeline cannot flush MEM.
- Read-after-write to the same word: a read accepted after the write's DONE edge returns the new data.

## Structure
- FSM state encodings (`MEM_ST_IDLE` / `MEM_ST_WAIT` / `MEM_ST_DONE`, 2 bits) go in `mips_define.vh`, next to the existing control constants.
- One sub-module, `data_ram`: 2^ADDR_WIDTH x 32, synchronous write, asynchronous read. The responder owns the FSM, counter, request latches and error checks.
- Top-level integration: `mem_stall` ORs into the controller's stall path, disabling IF/ID/EXE/MEM and resetting WB. That change is made in the controller, not here.

## Test plan
- `WAIT_CYCLES` = 2. SW `addr` 0x10, `data` 0xDEADBEEF, then LW 0x10.
  - Each access: `mem_stall` high for 2 cycles, then `ack`.
  - LW `rdata` = 0xDEADBEEF.
- `WAIT_CYCLES` = 0. SW 0x4 = 0x12345678, then LW 0x4 the next cycle.
  - Same-cycle `ack`, `mem_stall` never high, `rdata` = 0x12345678.
- LW 0x0000_1003 (unaligned): after `WAIT_CYCLES`, `ack` = 1, `err` = 1, `rdata` = 0. The addressed word is unchanged.
- `ADDR_WIDTH` = 10. SW 0x1000 = 0xA5A5A5A5, then LW 0x0.
  - Returns 0xA5A5A5A5 because the address wraps.
- SW 0x20 = 0x1, with `rst` pulled low during DONE.
  - Outputs return to 0 and state to IDLE.
  - A later LW 0x20 returns the previous contents, since the write was dropped.
- `req_ren` = `req_wen` = 1 at 0x8: `ack` with `err` = 1 and no write. A later LW 0x8 returns the old value.
